// File: rtl/alu_operand_stage.sv
// ---------------------------------------------------------------------------
// alu_operand_stage
//   Operand-fetch / writeback sequencer wrapped around an external 16-bit ALU.
//   Owns the 8x16 register file and runs one instruction per request through
//   IDLE -> LOAD_A -> LOAD_B -> EXEC -> WB.
//
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   start                 instruction request, sampled in IDLE only
//   rd, rn, rm            destination / A-operand / B-operand register
//   op                    ALU op (00 ADD, 01 SUB, 10 AND, 11 NOT)
//   shift                 B shift (00 none, 01 LSL1, 10 LSR1, 11 ASR1)
//   use_imm, imm          select unshifted immediate as B
//   write_rd              0: update flags only (compare)
//   ext_we/waddr/wdata    external register write, IDLE only
//   dbg_raddr, dbg_rdata  combinational debug read port
//   alu_a, alu_b, alu_op  operands and opcode presented to the ALU
//   alu_out, alu_z/n/v    result and flags returned by the ALU
//   status                {Z,N,V} captured in the last EXEC
//   busy                  high whenever the sequencer is not IDLE
//   done                  one-cycle completion pulse
// ---------------------------------------------------------------------------
module alu_operand_stage #(
  parameter int NREGS = 8,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       rd,
  input  logic [2:0]       rn,
  input  logic [2:0]       rm,
  input  logic [1:0]       op,
  input  logic [1:0]       shift,
  input  logic             use_imm,
  input  logic [WIDTH-1:0] imm,
  input  logic             write_rd,
  input  logic             ext_we,
  input  logic [2:0]       ext_waddr,
  input  logic [WIDTH-1:0] ext_wdata,
  input  logic [2:0]       dbg_raddr,
  output logic [WIDTH-1:0] dbg_rdata,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [1:0]       alu_op,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_z,
  input  logic             alu_n,
  input  logic             alu_v,
  output logic [2:0]       status,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_A = 3'd1,
    LOAD_B = 3'd2,
    EXEC   = 3'd3,
    WB     = 3'd4
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [WIDTH-1:0] regs_q [NREGS];
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] c_q;
  logic [2:0]       status_q;
  logic             done_q;

  // Instruction fields captured when a request is accepted
  logic [2:0]       rd_q;
  logic [2:0]       rn_q;
  logic [2:0]       rm_q;
  logic [1:0]       op_q;
  logic [1:0]       shift_q;
  logic             use_imm_q;
  logic [WIDTH-1:0] imm_q;
  logic             write_rd_q;

  // Single-bit barrel for the B operand; the vacated bit of LSR is zero,
  // of ASR a copy of the sign bit.
  function automatic logic [WIDTH-1:0] shift_b(input logic [WIDTH-1:0] x,
                                               input logic [1:0]       s);
    logic [WIDTH-1:0] r;
    case (s)
      2'b01:   r = {x[WIDTH-2:0], 1'b0};
      2'b10:   r = {1'b0, x[WIDTH-1:1]};
      2'b11:   r = {x[WIDTH-1], x[WIDTH-1:1]};
      default: r = x;
    endcase
    return r;
  endfunction

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: fixed five-step sequence, leaving IDLE only on start
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD_A;
        end else begin
          state_d = IDLE;
        end
      end
      LOAD_A:  state_d = LOAD_B;
      LOAD_B:  state_d = EXEC;
      EXEC:    state_d = WB;
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: register file, operand latches, result/flag capture, done pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= {WIDTH{1'b0}};
      end
      a_q        <= {WIDTH{1'b0}};
      b_q        <= {WIDTH{1'b0}};
      c_q        <= {WIDTH{1'b0}};
      status_q   <= 3'b000;
      done_q     <= 1'b0;
      rd_q       <= 3'd0;
      rn_q       <= 3'd0;
      rm_q       <= 3'd0;
      op_q       <= 2'b00;
      shift_q    <= 2'b00;
      use_imm_q  <= 1'b0;
      imm_q      <= {WIDTH{1'b0}};
      write_rd_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // External write and a new request may share an edge; the
          // operand reads happen later, so they see the written value.
          if (ext_we) begin
            regs_q[ext_waddr] <= ext_wdata;
          end
          if (start) begin
            rd_q       <= rd;
            rn_q       <= rn;
            rm_q       <= rm;
            op_q       <= op;
            shift_q    <= shift;
            use_imm_q  <= use_imm;
            imm_q      <= imm;
            write_rd_q <= write_rd;
          end
        end
        LOAD_A: begin
          a_q <= regs_q[rn_q];
        end
        LOAD_B: begin
          b_q <= use_imm_q ? imm_q : shift_b(regs_q[rm_q], shift_q);
        end
        EXEC: begin
          c_q      <= alu_out;
          status_q <= {alu_z, alu_n, alu_v};
        end
        WB: begin
          if (write_rd_q) begin
            regs_q[rd_q] <= c_q;
          end
          done_q <= 1'b1;
        end
        default: begin
          done_q <= 1'b0;
        end
      endcase
    end
  end

  assign dbg_rdata = regs_q[dbg_raddr];
  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign alu_op    = op_q;
  assign status    = status_q;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
// ---------------------------------------------------------------------------
// tb_alu_operand_stage
//   Directed bench for alu_operand_stage. A small behavioural ALU stands in
//   for the real one; expected register, flag and timing values are written
//   out by hand for each instruction.
// ---------------------------------------------------------------------------
module tb_alu_operand_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  rd, rn, rm;
  logic [1:0]  op, shift;
  logic        use_imm;
  logic [15:0] imm;
  logic        write_rd;
  logic        ext_we;
  logic [2:0]  ext_waddr;
  logic [15:0] ext_wdata;
  logic [2:0]  dbg_raddr;
  logic [15:0] dbg_rdata;
  logic [15:0] alu_a, alu_b;
  logic [1:0]  alu_op;
  logic [15:0] alu_out;
  logic        alu_z, alu_n, alu_v;
  logic [2:0]  status;
  logic        busy;
  logic        done;

  int errors = 0;
  int checks = 0;

  alu_operand_stage dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .rd        (rd),
    .rn        (rn),
    .rm        (rm),
    .op        (op),
    .shift     (shift),
    .use_imm   (use_imm),
    .imm       (imm),
    .write_rd  (write_rd),
    .ext_we    (ext_we),
    .ext_waddr (ext_waddr),
    .ext_wdata (ext_wdata),
    .dbg_raddr (dbg_raddr),
    .dbg_rdata (dbg_rdata),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_op    (alu_op),
    .alu_out   (alu_out),
    .alu_z     (alu_z),
    .alu_n     (alu_n),
    .alu_v     (alu_v),
    .status    (status),
    .busy      (busy),
    .done      (done)
  );

  always #10 clk = ~clk;

  // Behavioural ALU: ADD, SUB, AND, NOT B; V only meaningful for ADD/SUB
  always_comb begin
    alu_out = 16'h0000;
    alu_v   = 1'b0;
    case (alu_op)
      2'b00: begin
        alu_out = alu_a + alu_b;
        alu_v   = (alu_a[15] == alu_b[15]) && (alu_out[15] != alu_a[15]);
      end
      2'b01: begin
        alu_out = alu_a - alu_b;
        alu_v   = (alu_a[15] != alu_b[15]) && (alu_out[15] != alu_a[15]);
      end
      2'b10:   alu_out = alu_a & alu_b;
      default: alu_out = ~alu_b;
    endcase
    alu_z = (alu_out == 16'h0000);
    alu_n = alu_out[15];
  end

  // --- drivers (called at a falling edge, return at a falling edge) -------
  task automatic ext_write(input logic [2:0] a, input logic [15:0] d);
    ext_we = 1'b1; ext_waddr = a; ext_wdata = d;
    @(negedge clk);
    ext_we = 1'b0;
  endtask

  task automatic launch(input logic [2:0] rd_i, input logic [2:0] rn_i,
                        input logic [2:0] rm_i, input logic [1:0] op_i,
                        input logic [1:0] sh_i, input logic ui_i,
                        input logic [15:0] imm_i, input logic wr_i);
    rd = rd_i; rn = rn_i; rm = rm_i; op = op_i; shift = sh_i;
    use_imm = ui_i; imm = imm_i; write_rd = wr_i; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Cycles from the accepting edge until done is seen (20 = never came)
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (done !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic read_reg(input logic [2:0] a, output logic [15:0] v);
    @(negedge clk);
    dbg_raddr = a;
    #1;
    v = dbg_rdata;
  endtask

  // --- scenarios ----------------------------------------------------------
  task automatic test_reset();
    logic [15:0] v;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL reset_ctrl busy=%b done=%b want 0 0", busy, done);
    end
    checks++;
    if (status !== 3'b000 || alu_a !== 16'h0 || alu_b !== 16'h0 || alu_op !== 2'b00) begin
      errors++;
      $display("FAIL reset_out status=%b a=%h b=%h op=%b want 000 0000 0000 00",
               status, alu_a, alu_b, alu_op);
    end
    for (int i = 0; i < 8; i++) begin
      read_reg(i[2:0], v);
      checks++;
      if (v !== 16'h0000) begin
        errors++; $display("FAIL reset_reg R%0d got %h want 0000", i, v);
      end
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_add();
    int cyc;
    logic [15:0] v;
    ext_write(3'd1, 16'h0005);
    ext_write(3'd2, 16'h0003);
    launch(3'd3, 3'd1, 3'd2, 2'b00, 2'b00, 1'b0, 16'h0, 1'b1);
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL add_busy got %b want 1", busy);
    end
    wait_done(cyc);
    checks++;
    if (cyc !== 4) begin
      errors++; $display("FAIL add_latency got %0d want 4", cyc);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL add_busy_end got %b want 0", busy);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      errors++; $display("FAIL add_done_width done still %b want 0", done);
    end
    read_reg(3'd3, v);
    checks++;
    if (v !== 16'h0008) begin
      errors++; $display("FAIL add_r3 got %h want 0008", v);
    end
    checks++;
    if (status !== 3'b000) begin
      errors++; $display("FAIL add_status got %b want 000", status);
    end
  endtask

  task automatic test_compare();
    int cyc;
    logic [15:0] v;
    launch(3'd7, 3'd1, 3'd1, 2'b01, 2'b00, 1'b0, 16'h0, 1'b0);
    wait_done(cyc);
    checks++;
    if (status !== 3'b100) begin
      errors++; $display("FAIL cmp_status got %b want 100", status);
    end
    read_reg(3'd7, v);
    checks++;
    if (v !== 16'h0000) begin
      errors++; $display("FAIL cmp_r7 got %h want 0000", v);
    end
  endtask

  task automatic test_imm_overflow();
    int cyc;
    logic [15:0] v;
    @(negedge clk);
    ext_write(3'd4, 16'h7FFF);
    launch(3'd5, 3'd4, 3'd0, 2'b00, 2'b00, 1'b1, 16'h0001, 1'b1);
    wait_done(cyc);
    read_reg(3'd5, v);
    checks++;
    if (v !== 16'h8000) begin
      errors++; $display("FAIL imm_r5 got %h want 8000", v);
    end
    checks++;
    if (status !== 3'b011) begin
      errors++; $display("FAIL imm_status got %b want 011", status);
    end
  endtask

  task automatic test_not_asr();
    int cyc;
    logic [15:0] v;
    @(negedge clk);
    ext_write(3'd6, 16'h8004);
    launch(3'd0, 3'd0, 3'd6, 2'b11, 2'b11, 1'b0, 16'h0, 1'b1);
    wait_done(cyc);
    checks++;
    if (alu_b !== 16'hC002) begin
      errors++; $display("FAIL not_b got %h want C002", alu_b);
    end
    read_reg(3'd0, v);
    checks++;
    if (v !== 16'h3FFD) begin
      errors++; $display("FAIL not_r0 got %h want 3FFD", v);
    end
    checks++;
    if (status !== 3'b000) begin
      errors++; $display("FAIL not_status got %b want 000", status);
    end
  endtask

  task automatic test_busy_ignore();
    int ndone;
    logic [15:0] v;
    @(negedge clk);
    // AND R6 = R1 & R2 = 5 & 3
    launch(3'd6, 3'd1, 3'd2, 2'b10, 2'b00, 1'b0, 16'h0, 1'b1);
    // Competing request (ADD into R4) and external write to R4 while busy
    rd = 3'd4; rn = 3'd1; rm = 3'd1; op = 2'b00; write_rd = 1'b1; start = 1'b1;
    ext_we = 1'b1; ext_waddr = 3'd4; ext_wdata = 16'hDEAD;
    @(negedge clk);
    start = 1'b0; ext_we = 1'b0;
    ndone = 0;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    checks++;
    if (ndone !== 1) begin
      errors++; $display("FAIL busy_done_count got %0d want 1", ndone);
    end
    read_reg(3'd6, v);
    checks++;
    if (v !== 16'h0001) begin
      errors++; $display("FAIL busy_r6 got %h want 0001", v);
    end
    read_reg(3'd4, v);
    checks++;
    if (v !== 16'h7FFF) begin
      errors++; $display("FAIL busy_r4 got %h want 7FFF", v);
    end
  endtask

  task automatic test_shift_modes();
    logic [15:0] exp_r [4];
    logic [2:0]  exp_s [4];
    logic [15:0] v;
    int cyc;
    exp_r[0] = 16'h8003; exp_s[0] = 3'b010;
    exp_r[1] = 16'h0006; exp_s[1] = 3'b000;
    exp_r[2] = 16'h4001; exp_s[2] = 3'b000;
    exp_r[3] = 16'hC001; exp_s[3] = 3'b010;
    @(negedge clk);
    ext_write(3'd2, 16'h8003);
    for (int s = 0; s < 4; s++) begin
      // R3 = R7(0) + shift(R2)
      launch(3'd3, 3'd7, 3'd2, 2'b00, s[1:0], 1'b0, 16'h0, 1'b1);
      wait_done(cyc);
      read_reg(3'd3, v);
      checks++;
      if (v !== exp_r[s]) begin
        errors++; $display("FAIL shift%0d_r3 got %h want %h", s, v, exp_r[s]);
      end
      checks++;
      if (status !== exp_s[s]) begin
        errors++; $display("FAIL shift%0d_status got %b want %b", s, status, exp_s[s]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    logic [15:0] v;
    @(negedge clk);
    launch(3'd1, 3'd1, 3'd1, 2'b00, 2'b00, 1'b0, 16'h0, 1'b1);   // R1 = 5+5
    wait_done(cyc);
    // Start issued while done is high; it must be accepted immediately
    launch(3'd2, 3'd1, 3'd1, 2'b00, 2'b00, 1'b0, 16'h0, 1'b1);   // R2 = A+A
    wait_done(cyc);
    checks++;
    if (cyc !== 4) begin
      errors++; $display("FAIL b2b_latency got %0d want 4", cyc);
    end
    read_reg(3'd1, v);
    checks++;
    if (v !== 16'h000A) begin
      errors++; $display("FAIL b2b_r1 got %h want 000A", v);
    end
    read_reg(3'd2, v);
    checks++;
    if (v !== 16'h0014) begin
      errors++; $display("FAIL b2b_r2 got %h want 0014", v);
    end
  endtask

  task automatic test_write_and_start();
    int cyc;
    logic [15:0] v;
    @(negedge clk);
    ext_we = 1'b1; ext_waddr = 3'd1; ext_wdata = 16'h1234;
    launch(3'd3, 3'd1, 3'd7, 2'b00, 2'b00, 1'b0, 16'h0, 1'b1);   // R3 = R1 + R7
    ext_we = 1'b0;
    wait_done(cyc);
    read_reg(3'd3, v);
    checks++;
    if (v !== 16'h1234) begin
      errors++; $display("FAIL same_edge_r3 got %h want 1234", v);
    end
  endtask

  task automatic test_reset_mid();
    int ndone;
    logic [15:0] v;
    @(negedge clk);
    launch(3'd5, 3'd1, 3'd2, 2'b00, 2'b00, 1'b0, 16'h0, 1'b1);
    repeat (2) @(negedge clk);   // now in EXEC
    reset = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL mid_busy got %b want 0", busy);
    end
    checks++;
    if (alu_a !== 16'h0 || alu_b !== 16'h0 || status !== 3'b000) begin
      errors++; $display("FAIL mid_out a=%h b=%h status=%b want 0000 0000 000",
                         alu_a, alu_b, status);
    end
    @(negedge clk);
    reset = 1'b0;
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    checks++;
    if (ndone !== 0) begin
      errors++; $display("FAIL mid_done got %0d pulses want 0", ndone);
    end
    for (int i = 0; i < 8; i++) begin
      read_reg(i[2:0], v);
      checks++;
      if (v !== 16'h0000) begin
        errors++; $display("FAIL mid_reg R%0d got %h want 0000", i, v);
      end
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; rd = 3'd0; rn = 3'd0; rm = 3'd0;
    op = 2'b00; shift = 2'b00; use_imm = 1'b0; imm = 16'h0; write_rd = 1'b0;
    ext_we = 1'b0; ext_waddr = 3'd0; ext_wdata = 16'h0; dbg_raddr = 3'd0;
    test_reset();
    test_add();
    test_compare();
    test_imm_overflow();
    test_not_asr();
    test_busy_ignore();
    test_shift_modes();
    test_back_to_back();
    test_write_and_start();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
Operand-fetch and writeback stage wrapped around the 16-bit ALU in the datapath. Holds the 8x16 register file. Sequences one instruction per request: reads the A operand, reads and optionally shifts the B operand (or selects an immediate), presents both with the opcode to the ALU, then captures the result and Z/N/V flags. Drives the ALU's Ain/Bin/ALUop inputs and consumes its out/Z/N/V outputs.

Parameters:
NREGS, 8, number of general registers. Fixed at 8 because register addresses are 3 bits.
WIDTH, 16, data width. Must match the ALU.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high; clears all state
start  input  1  request; sampled only in IDLE
rd  input  3  destination register
rn  input  3  A-operand register
rm  input  3  B-operand register
op  input  2  ALU op: 00 ADD, 01 SUB, 10 AND, 11 NOT
shift  input  2  B shift: 00 none, 01 LSL1, 10 LSR1, 11 ASR1
use_imm  input  1  1: B = imm, unshifted
imm  input  16  immediate operand
write_rd  input  1  0: flags only (compare); no register write
ext_we  input  1  external register write, honoured in IDLE only
ext_waddr  input  3  external write address
ext_wdata  input  16  external write data
dbg_raddr  input  3  debug read address
dbg_rdata  output  16  combinational read of R[dbg_raddr]
alu_a  output  16  to ALU Ain
alu_b  output  16  to ALU Bin
alu_op  output  2  to ALU ALUop
alu_out  input  16  from ALU out
alu_z  input  1  from ALU Z
alu_n  input  1  from ALU N
alu_v  input  1  from ALU V
status  output  3  {Z,N,V} from the last EXEC
busy  output  1  high when state is not IDLE
done  output  1  one-cycle pulse on completion

Behaviour:
- Reset (asynchronous, active-high) forces all of the following immediately, including mid-instruction:
  - state = IDLE.
  - R0..R7 = 0; A, B, C = 0; status = 000.
  - alu_op register = 00; busy = 0; done = 0.
  - Latched instruction fields = 0.
  - No writeback of an aborted instruction occurs.
- State machine. Each transition happens on a clock edge.
  - IDLE: if start = 1, latch rd/rn/rm/op/shift/use_imm/imm/write_rd, then go to LOAD_A. Otherwise stay in IDLE.
  - LOAD_A: A <= R[rn_q]; go to LOAD_B.
  - LOAD_B: B <= use_imm_q ? imm_q : shift(R[rm_q]); go to EXEC.
  - EXEC: C <= alu_out; status <= {alu_z, alu_n, alu_v}; go to WB.
  - WB: if write_rd_q, R[rd_q] <= C. done <= 1. Go to IDLE.
- Shift functions:
  - LSL1 = {x[14:0], 0}.
  - LSR1 = {0, x[15:1]}.
  - ASR1 = {x[15], x[15:1]}.
- alu_a = A, alu_b = B, alu_op = op_q at all times. The ALU result is meaningful during EXEC.
- Status is captured for every op, including AND and NOT. Status is unchanged in all other states.
- Latency and timing:
  - Start sampled at edge 0; done is high for exactly the cycle after edge 4.
  - The register file shows the new value from edge 4.
  - busy is high from edge 0 through edge 4.
  - A new start may be accepted in the same cycle that done is high, because state is IDLE.
- start while busy is ignored. Fields are not re-latched.
- ext_we while busy is ignored.
- ext_we and start in the same IDLE edge: both take effect. LOAD_A/LOAD_B read after the write, so the new value is used.
- rd = rn = rm is legal. Reads occur before writeback, so the old value is used.
- Add, subtract and shift wrap modulo 2^16 with no saturation.

Test Plan:
1. Reset; ext-write R1=0x0005, R2=0x0003; start ADD rd=3, rn=1, rm=2, shift=00, write_rd=1 -> done 4 cycles after start; R3=0x0008; status=000.
2. SUB rd=7, rn=1, rm=1, write_rd=0 (compare) -> status Z=1, N=0, V=0 (100); R7 stays 0x0000.
3. R4=0x7FFF; ADD rn=4, use_imm=1, imm=0x0001, rd=5 -> R5=0x8000; status=011.
4. R6=0x8004; NOT rm=6, shift=11, rd=0 -> B=0xC002; R0=0x3FFD; status=000.
5. Second start and an ext_we pulse while busy -> both ignored; exactly one done; the target register is untouched by the ext write.
6. Assert reset while in EXEC -> busy=0 immediately; no done pulse; R0..R7, status, alu_a and alu_b all read 0.
